// File: rtl/multiword_add_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// multiword_add_sequencer_pkg
//
// Shared definitions for the multi-word add/subtract sequencer:
//   - WORD_W        : width of the single shared word adder (16 bits)
//   - seq_state_e   : sequencer FSM states (IDLE, RUN, DONE)
//   - idxWidth()    : width of the word-select counter for a given WORDS
// ---------------------------------------------------------------------------
package multiword_add_sequencer_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // A single-word configuration still needs a 1-bit index so that the
    // counter and its comparisons keep a legal, non-zero width.
    function automatic int idxWidth(input int words);
        return (words <= 1) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/multiword_add_sequencer_if.sv
// ---------------------------------------------------------------------------
// multiword_add_sequencer_if
//
// Bundles the operand channel and the result channel of the sequencer.
//
// Operand channel (source -> sequencer):
//   in_valid, a[W], b[W], sub, cin  ; in_ready back to the source
// Result channel (sequencer -> consumer):
//   out_valid, sum[W], cout, overflow ; out_ready back to the sequencer
//
// Modports:
//   master : the side that supplies operands and consumes results
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface multiword_add_sequencer_if
    import multiword_add_sequencer_pkg::*;
#(
    parameter int WORDS = 4
) ();

    localparam int W = WORD_W * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input  in_ready, out_valid, sum, cout, overflow
    );

    modport slave (
        input  in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, overflow
    );

endinterface

// File: rtl/multiword_add_sequencer_adder.sv
// ---------------------------------------------------------------------------
// WordWiseAdder
//
// Purely combinational 16-bit carry-lookahead adder used as the one shared
// arithmetic element of the multi-word sequencer.
//
// Ports:
//   a_i[16] : addend word
//   b_i[16] : addend word (already inverted by the caller for subtract)
//   c_i     : carry into bit 0
//   s_o[16] : sum word, mod 2^16
//   c_o     : carry out of bit 15
//
// Organisation: four 4-bit groups. Group generate/propagate terms feed a
// flattened group-level lookahead so that group carries do not ripple; bit
// carries are then formed inside each group from its group carry.
// ---------------------------------------------------------------------------
module WordWiseAdder (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        c_i,
    output logic [15:0] s_o,
    output logic        c_o
);

    logic [15:0] bitG;
    logic [15:0] bitP;
    logic [3:0]  grpG;
    logic [3:0]  grpP;
    logic [4:0]  grpC;
    logic [16:0] bitC;

    assign bitG = a_i & b_i;
    assign bitP = a_i ^ b_i;

    // Group generate/propagate for each 4-bit slice.
    always_comb begin
        grpG = '0;
        grpP = '0;
        for (int j = 0; j < 4; j++) begin
            grpG[j] = bitG[4*j+3]
                    | (bitP[4*j+3] & bitG[4*j+2])
                    | (bitP[4*j+3] & bitP[4*j+2] & bitG[4*j+1])
                    | (bitP[4*j+3] & bitP[4*j+2] & bitP[4*j+1] & bitG[4*j]);
            grpP[j] = &bitP[4*j +: 4];
        end
    end

    // Second-level lookahead: every group carry is a two-level function of
    // the group terms and c_i, written out so it does not ripple.
    always_comb begin
        grpC    = '0;
        grpC[0] = c_i;
        grpC[1] = grpG[0] | (grpP[0] & c_i);
        grpC[2] = grpG[1] | (grpP[1] & grpG[0]) | (grpP[1] & grpP[0] & c_i);
        grpC[3] = grpG[2] | (grpP[2] & grpG[1]) | (grpP[2] & grpP[1] & grpG[0])
                | (grpP[2] & grpP[1] & grpP[0] & c_i);
        grpC[4] = grpG[3] | (grpP[3] & grpG[2]) | (grpP[3] & grpP[2] & grpG[1])
                | (grpP[3] & grpP[2] & grpP[1] & grpG[0])
                | (grpP[3] & grpP[2] & grpP[1] & grpP[0] & c_i);
    end

    // Bit carries inside each group start from that group's lookahead carry,
    // so the longest chain is only four bits deep.
    always_comb begin
        bitC = '0;
        for (int j = 0; j < 4; j++) begin
            bitC[4*j] = grpC[j];
            for (int i = 0; i < 3; i++) begin
                bitC[4*j+i+1] = bitG[4*j+i] | (bitP[4*j+i] & bitC[4*j+i]);
            end
        end
        bitC[16] = grpC[4];
    end

    assign s_o = bitP ^ bitC[15:0];
    assign c_o = bitC[16];

endmodule

// File: rtl/multiword_add_sequencer.sv
// ---------------------------------------------------------------------------
// multiword_add_sequencer
//
// Performs a W = 16*WORDS bit add or subtract by stepping one shared 16-bit
// WordWiseAdder across the operand words, least-significant word first, with
// the carry held in a register between words.
//
// Parameters:
//   WORDS : number of 16-bit slices (1..16)
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : multiword_add_sequencer_if.slave
//          operand channel in_valid/in_ready/a/b/sub/cin,
//          result channel out_valid/out_ready/sum/cout/overflow
//
// Behaviour summary:
//   IDLE : in_ready=1; an accepted bundle latches a and (sub ? ~b : b), the
//          carry register is seeded with cin ^ sub, the sum register clears.
//   RUN  : one word per cycle through the adder; on the last word the final
//          carry and signed overflow are captured.
//   DONE : out_valid=1 with all results held until out_ready.
// ---------------------------------------------------------------------------
module multiword_add_sequencer
    import multiword_add_sequencer_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    multiword_add_sequencer_if.slave    bus
);

    localparam int                W        = WORD_W * WORDS;
    localparam int                IDX_W    = idxWidth(WORDS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);

    seq_state_e         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       opA_q, opA_d;
    logic [W-1:0]       opB_q, opB_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [WORD_W-1:0]  wordA;
    logic [WORD_W-1:0]  wordB;
    logic [WORD_W-1:0]  wordSum;
    logic               wordCout;
    logic               lastWord;

    // Word select for the shared adder. opB_q already holds the inverted
    // operand for subtract, so the adder never needs to know the operation.
    assign wordA    = opA_q[WORD_W*int'(idx_q) +: WORD_W];
    assign wordB    = opB_q[WORD_W*int'(idx_q) +: WORD_W];
    assign lastWord = (idx_q == LAST_IDX);

    WordWiseAdder u_wordAdder (
        .a_i (wordA),
        .b_i (wordB),
        .c_i (carry_q),
        .s_o (wordSum),
        .c_o (wordCout)
    );

    // State and datapath registers. Reset clears everything so that no
    // partial result from an aborted operation can ever be observed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            opA_q   <= '0;
            opB_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath update. Everything holds by default; only the
    // accept, per-word step and result handshake move the block forward.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    opA_d   = bus.a;
                    opB_d   = bus.sub ? ~bus.b : bus.b;
                    // A - B - borrow = A + ~B + (1 - borrow)
                    carry_d = bus.cin ^ bus.sub;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                sum_d[WORD_W*int'(idx_q) +: WORD_W] = wordSum;
                carry_d = wordCout;
                if (lastWord) begin
                    // Overflow: both addends share a sign that the result lacks.
                    cout_d  = wordCout;
                    ovf_d   = (opA_q[W-1] == opB_q[W-1]) &&
                              (wordSum[WORD_W-1] != opA_q[W-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake flags decode the registered state only; no input reaches an
    // output without passing through a register.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// ---------------------------------------------------------------------------
// tb_multiword_add_sequencer
//
// Self-checking bench for multiword_add_sequencer with WORDS=4. Expected
// results come from whole-width arithmetic on the original operands; a
// queue of pending results drives a per-cycle compare of the handshake
// flags, latency and result fields.
// ---------------------------------------------------------------------------
module tb_multiword_add_sequencer;

    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acceptCycle;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    multiword_add_sequencer_if #(.WORDS(WORDS)) bus ();

    multiword_add_sequencer #(.WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t          expQ[$];
    int            checks     = 0;
    int            passes     = 0;
    int            cycleCnt   = 0;
    int            readyMode  = 0;
    bit            monitorOn  = 1'b0;
    int            age;
    logic [W-1:0]  lastSum;
    logic          lastCout;
    logic          lastOvf;

    // Cycle counter used to measure accept-to-valid latency.
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [W-1:0] act,
                               input logic [W-1:0] req);
        checks++;
        if (act === req) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Whole-width reference: unsigned arithmetic for sum and carry/borrow,
    // signed arithmetic on sign-extended values for overflow.
    function automatic logic [W+1:0] refModel(input logic [W-1:0] a,
                                              input logic [W-1:0] b,
                                              input logic sub,
                                              input logic cin);
        logic [W+1:0]        ua, ub, uc, ur;
        logic signed [W+1:0] sa, sb, sc, sr;
        logic                c, ovf;
        ua = {2'b00, a};
        ub = {2'b00, b};
        uc = {{(W+1){1'b0}}, cin};
        sa = $signed({{2{a[W-1]}}, a});
        sb = $signed({{2{b[W-1]}}, b});
        sc = $signed(uc);
        if (!sub) begin
            ur = ua + ub + uc;
            sr = sa + sb + sc;
            c  = ur[W];
        end else begin
            ur = ua - ub - uc;
            sr = sa - sb - sc;
            c  = (ua >= ub + uc);
        end
        ovf = (sr < -(66'sd1 <<< (W-1))) || (sr >= (66'sd1 <<< (W-1)));
        return {ovf, c, ur[W-1:0]};
    endfunction

    // Result consumer: always ready, random, or stalled.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (readyMode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Per-cycle compare against the pending-result queue.
    always @(negedge clk) begin
        if (monitorOn && !rst) begin
            if (expQ.size() == 0) begin
                checkOutput("idle out_valid", W'(bus.out_valid), W'(1'b0));
                checkOutput("idle in_ready", W'(bus.in_ready), W'(1'b1));
            end else begin
                age = cycleCnt - expQ[0].acceptCycle;
                checkOutput("busy in_ready", W'(bus.in_ready), W'(1'b0));
                checkOutput("out_valid latency", W'(bus.out_valid), W'(age >= WORDS));
                if (bus.out_valid) begin
                    checkOutput("sum", bus.sum, expQ[0].sum);
                    checkOutput("cout", W'(bus.cout), W'(expQ[0].cout));
                    checkOutput("overflow", W'(bus.overflow), W'(expQ[0].ovf));
                    if (bus.out_ready) begin
                        lastSum  = bus.sum;
                        lastCout = bus.cout;
                        lastOvf  = bus.overflow;
                        void'(expQ.pop_front());
                    end
                end
            end
        end
    end

    // Drive one bundle and hold it until accepted. Entered and left just
    // after a rising edge; inputs are scrambled after acceptance.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic cin);
        logic [W+1:0] r;
        bit           ir;
        bit           accepted;
        exp_t         e;
        accepted     = 1'b0;
        bus.a        = a;
        bus.b        = b;
        bus.sub      = sub;
        bus.cin      = cin;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            ir = bus.in_ready;
            @(posedge clk);
            if (ir) begin
                accepted = 1'b1;
                break;
            end
            #1;
        end
        #1;
        if (accepted) begin
            r             = refModel(a, b, sub, cin);
            e.sum         = r[W-1:0];
            e.cout        = r[W];
            e.ovf         = r[W+1];
            e.acceptCycle = cycleCnt;
            expQ.push_back(e);
        end else begin
            checkOutput("accept timeout", W'(1'b0), W'(1'b1));
        end
        bus.in_valid = 1'b0;
        bus.a        = {$urandom, $urandom};
        bus.b        = {$urandom, $urandom};
        bus.sub      = 1'($urandom_range(0, 1));
        bus.cin      = 1'($urandom_range(0, 1));
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (expQ.size() != 0) begin
            checkOutput({name, " drain timeout"}, W'(expQ.size()), W'(0));
            expQ.delete();
        end
    endtask

    task automatic runDirected(input string name, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic sub,
                               input logic cin, input logic [W-1:0] xSum,
                               input logic xCout, input logic xOvf);
        logic [W+1:0] r;
        r = refModel(a, b, sub, cin);
        checkOutput({name, " model sum"}, r[W-1:0], xSum);
        checkOutput({name, " model cout/ovf"}, W'(r[W+1:W]), W'({xOvf, xCout}));
        applyStimulus(a, b, sub, cin);
        waitDrain(name);
        checkOutput({name, " sum"}, lastSum, xSum);
        checkOutput({name, " cout"}, W'(lastCout), W'(xCout));
        checkOutput({name, " overflow"}, W'(lastOvf), W'(xOvf));
    endtask

    function automatic logic [15:0] pickWord();
        case ($urandom_range(0, 5))
            0:       return 16'hFFFF;
            1:       return 16'h0000;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [W-1:0] pickOperand();
        logic [W-1:0] v;
        for (int i = 0; i < WORDS; i++) v[16*i +: 16] = pickWord();
        return v;
    endfunction

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.sub      = 1'b0;
        bus.cin      = 1'b0;
        #1 rst = 1'b1;
        #1;
        checkOutput("reset out_valid", W'(bus.out_valid), W'(1'b0));
        checkOutput("reset in_ready", W'(bus.in_ready), W'(1'b1));
        checkOutput("reset sum", bus.sum, '0);
        checkOutput("reset cout/ovf", W'({bus.cout, bus.overflow}), W'(2'b00));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        monitorOn = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed vectors");
        runDirected("carry ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                    64'h0, 1'b1, 1'b0);
        runDirected("signed ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                    64'h8000_0000_0000_0000, 1'b0, 1'b1);
        runDirected("sub borrow", 64'h0, 64'h1, 1'b1, 1'b0,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        runDirected("carry-in", 64'h0000_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1,
                    64'h0001_0000_0000_0000, 1'b0, 1'b0);
        runDirected("sub borrow-in", 64'h5, 64'h2, 1'b1, 1'b1,
                    64'h2, 1'b1, 1'b0);

        $display("[TB] backpressure");
        readyMode = 2;
        applyStimulus(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
        fork
            applyStimulus(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0);
            begin
                for (int n = 0; n < 20 && !bus.out_valid; n++) @(negedge clk);
                repeat (5) @(negedge clk);
                readyMode = 0;
            end
        join
        waitDrain("backpressure");
        checkOutput("backpressure 2nd sum", lastSum, 64'h7FFF_FFFF_FFFF_FFFF);
        checkOutput("backpressure 2nd ovf", W'(lastOvf), W'(1'b1));

        $display("[TB] reset mid-operation");
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        expQ.delete();
        #1;
        checkOutput("abort out_valid", W'(bus.out_valid), W'(1'b0));
        checkOutput("abort in_ready", W'(bus.in_ready), W'(1'b1));
        checkOutput("abort sum", bus.sum, '0);
        checkOutput("abort cout/ovf", W'({bus.cout, bus.overflow}), W'(2'b00));
        @(posedge clk);
        #1 rst = 1'b0;
        runDirected("after abort", 64'h0000_0001_0000_FFFF, 64'h0000_0000_0000_0001,
                    1'b0, 1'b0, 64'h0000_0001_0001_0000, 1'b0, 1'b0);

        $display("[TB] randomized operations");
        readyMode = 1;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(pickOperand(), pickOperand(),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        readyMode = 0;
        waitDrain("random");

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/multiword_add_sequencer.md
# multiword_add_sequencer

Sequencer that performs WORDS×16-bit add/subtract by driving one shared 16-bit carry-lookahead word adder for WORDS consecutive cycles, least-significant word first. The carry is registered between words. Operands are accepted and results returned through valid/ready handshakes. The block sits between an operand source, such as a register file or DMA front end, and a result consumer, and serialises wide arithmetic onto a single narrow adder.

## Interface
Parameters:
- WORDS, 4, number of 16-bit slices; operand width W = 16*WORDS; legal range 1..16

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  operand bundle valid
- in_ready  out  1  block can accept operands (IDLE only)
- a  in  W  operand A
- b  in  W  operand B
- sub  in  1  1 = compute A − B, 0 = compute A + B
- cin  in  1  carry-in for add; borrow-in for sub
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  W  result
- cout  out  1  final carry out; for sub, 1 = no borrow
- overflow  out  1  signed (two's-complement) overflow of the W-bit result

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - Accept when in_valid&&in_ready.
  - On accept, latch a, and latch b as (sub ? ~b : b).
  - Set carry register = cin ^ sub.
  - Set idx=0, clear the sum register, go to RUN.
- RUN:
  - Each cycle, word adder inputs are a[idx], b'[idx] and the carry register.
  - At the clock edge, the adder output is written to sum word idx, its carry-out goes to the carry register, and idx increments.
  - When idx==WORDS−1 at the edge:
    - capture cout = adder carry-out.
    - capture overflow = (a_msb==b'_msb) && (sum_msb!=a_msb).
    - go to DONE.
- DONE:
  - out_valid=1.
  - sum, cout and overflow are held stable until out_valid&&out_ready, then the block returns to IDLE.
- No overlap: in_ready=0 in RUN and DONE. A new bundle is accepted no earlier than the cycle after the result handshake.
- Sub arithmetic:
  - A − B − borrow = A + ~B + (1 − borrow).
  - For sub, cin=1 means borrow-in.
- Width rules:
  - All word sums are mod 2^16.
  - idx is a $clog2(WORDS)-bit counter (minimum 1 bit). It never wraps past WORDS−1.
- Mid-operation changes: a, b, sub and cin may change after acceptance without effect.

## Timing
- Reset (asynchronous assert, any state):
  - state=IDLE, idx=0, carry=0.
  - sum=0, cout=0, overflow=0, out_valid=0, in_ready=1, all immediately.
  - Reset release is synchronous to clk.
- Reset mid-RUN or mid-DONE aborts the operation. No partial result is ever presented.
- Latency: accept at edge k → out_valid=1 after edge k+WORDS. With out_ready held high, the result handshake occurs at edge k+WORDS+1, so throughput is one operation per WORDS+2 cycles.
- out_valid never drops without a handshake, except on reset.
- in_ready is a registered-state decode. It does not depend combinationally on in_valid.
- out_valid and result outputs are registered. No combinational path from inputs to outputs.
- Critical path: one 16-bit CLA word add plus the carry-register setup.

## Structure
- Shared package:
  - state enum {IDLE, RUN, DONE}.
  - WORD_W=16 constant.
  - function for word-select index width.
- Sub-module: one instance of the team's existing 16-bit WordWiseAdder. It is the only arithmetic in the block.
- The sequencer itself is FSM + idx counter + carry/operand/sum registers.

## Test plan
All scenarios use WORDS=4.
- Add carry ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=1, sub=0, cin=0 → sum=0, cout=1, overflow=0; out_valid rises exactly 4 edges after accept.
- Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0, cin=0 → sum=0x8000_0000_0000_0000, cout=0, overflow=1.
- Subtract borrow: a=0, b=1, sub=1, cin=0 → sum=0xFFFF_FFFF_FFFF_FFFF, cout=0, overflow=0.
- Carry-in across words: a=0x0000_FFFF_FFFF_FFFF, b=0, sub=0, cin=1 → sum=0x0001_0000_0000_0000, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while presenting a second in_valid → sum stable, in_ready=0, second bundle accepted only after the result handshake.
- Reset mid-operation: assert rst after the 2nd RUN cycle → out_valid=0, sum=0, in_ready=1 without a clock edge; the next operation computes correctly.
